reg_file_param: RTL and testbench

Parametrised multi-entry register file that generalises the single 64-bit enabled register into a DEPTH x WIDTH array.
- One synchronous write port; NUM_RD combinational read ports.
- Optional hardwired-zero entry and optional write-to-read bypass.
- Serves as the architectural register file of the pipelined datapath, with X31 as zero by default.

---
 rtl/reg_pkg.sv | 17 +
 rtl/reg_word.sv | 37 +++
 rtl/reg_file_param.sv | 77 +++++++
 tb/tb_reg_file_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-file constants and the architectural register index type.
package reg_pkg;

    localparam int REG_WIDTH = 64;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = $clog2(REG_DEPTH);
    localparam int ZERO_REG  = 31;

    // Architectural register index as carried through the pipeline.
    typedef logic [REG_AW-1:0] addr_t;

    // True when an architectural index names the hardwired-zero register.
    function automatic logic is_zero_reg(addr_t idx);
        return idx == addr_t'(ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_word.sv
// One register-file entry: per-bit enable mux in front of a D flip-flop
// with synchronous clear.
module reg_word
    import reg_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Hold mux: each bit reloads itself unless the entry is enabled.
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            word_d[b] = en_i ? d_i[b] : word_q[b];
        end
    end

    // State register; reset wins over any pending write.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised DEPTH x WIDTH register file: one synchronous write port,
// NUM_RD combinational read ports, optional hardwired-zero entry and
// optional same-cycle write-to-read bypass.
module reg_file_param
    import reg_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = DEPTH - 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);
    localparam logic          ZERO_ON   = (ZERO_EN != 0);
    localparam logic          BYP_ON    = (BYPASS != 0);

    // Current contents of every entry as seen by the read muxes.
    logic [WIDTH-1:0] entry_q [DEPTH];

    // Storage array plus write decoder: each entry gets a one-hot enable.
    // The zero entry has no storage at all, so writes to it vanish and it
    // reads 0 even before the first reset.
    // NOTE: the register array is cleared by reset, since every entry must
    // read a defined 0 afterwards; no uninitialised state is exposed.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_ON && (i == ZERO_IDX)) begin : g_zero
            assign entry_q[i] = '0;
        end else begin : g_store
            logic entry_en;
            assign entry_en = wr_en && (wr_addr == AW'(i));

            reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk   (clk),
                .reset (reset),
                .en_i  (entry_en),
                .d_i   (wr_data),
                .q_o   (entry_q[i])
            );
        end
    end

    // Read ports: independent muxes, each with its own bypass compare.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [AW-1:0]    rd_idx;
        logic             byp_hit;
        logic [WIDTH-1:0] port_val;

        assign rd_idx  = rd_addr[k*AW +: AW];
        assign byp_hit = BYP_ON && !reset && wr_en && (wr_addr == rd_idx)
                         && !(ZERO_ON && (rd_idx == ZERO_ADDR));

        // Select stored entry, or in-flight write data on a bypass hit.
        // NOTE: port_val is assigned on every path, so no latch is inferred.
        always_comb begin
            port_val = entry_q[rd_idx];
            if (byp_hit) begin
                port_val = wr_data;
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = port_val;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: directed vector table, randomized
// run against an array-based reference model, and a small-configuration
// sequence.
module tb_reg_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration stimulus, shared by the bypass and no-bypass copies.
    logic         rst;
    logic         we;
    logic [4:0]   wa;
    logic [63:0]  wd;
    logic [9:0]   ra;
    logic [127:0] rd_a;
    logic [127:0] rd_b;

    // Small-configuration stimulus.
    logic        rst_c;
    logic        we_c;
    logic [1:0]  wa_c;
    logic [7:0]  wd_c;
    logic [5:0]  ra_c;
    logic [23:0] rd_c;

    reg_file_param dut_a (
        .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .rd_addr(ra), .rd_data(rd_a)
    );

    reg_file_param #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .rd_addr(ra), .rd_data(rd_b)
    );

    reg_file_param #(.WIDTH(8), .DEPTH(4), .NUM_RD(3), .ZERO_EN(0)) dut_c (
        .clk(clk), .reset(rst_c), .wr_en(we_c), .wr_addr(wa_c), .wr_data(wd_c),
        .rd_addr(ra_c), .rd_data(rd_c)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: plain array of architectural registers.
    logic [63:0] mem [32];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected read value for an index, for a copy with or without bypass.
    function automatic logic [63:0] model_read(input int idx, input bit bp);
        if (idx == 31) return 64'h0;
        if (bp && !rst && we && (int'(wa) == idx)) return wd;
        return mem[idx];
    endfunction

    task automatic drive(input bit r, input bit e, input int a, input logic [63:0] d,
                         input int r0, input int r1);
        rst = r;
        we  = e;
        wa  = 5'(a);
        wd  = d;
        ra  = {5'(r1), 5'(r0)};
        #1;
    endtask

    // Advance one edge and apply the architectural effect to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        end else if (we && wa != 5'd31) begin
            mem[wa] = wd;
        end
        #1;
    endtask

    typedef struct {
        bit          r;
        bit          e;
        int          a;
        logic [63:0] d;
        int          r0;
        int          r1;
        logic [63:0] e0;  // bypass copy, port 0
        logic [63:0] e1;  // bypass copy, port 1
        logic [63:0] n0;  // no-bypass copy, port 0
        logic [63:0] n1;  // no-bypass copy, port 1
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 1'b1,  5, 64'h123, 5, 5, 64'h0, 64'h0, 64'h0, 64'h0};
        tbl[1]  = '{1'b0, 1'b1,  5, 64'hDEAD_BEEF_0123_4567, 5, 6,
                    64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 64'h0};
        tbl[2]  = '{1'b0, 1'b0,  0, 64'h0, 5, 6,
                    64'hDEAD_BEEF_0123_4567, 64'h0, 64'hDEAD_BEEF_0123_4567, 64'h0};
        tbl[3]  = '{1'b0, 1'b1,  7, 64'h1234, 7, 5,
                    64'h1234, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'hDEAD_BEEF_0123_4567};
        tbl[4]  = '{1'b0, 1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 7,
                    64'h0, 64'h1234, 64'h0, 64'h1234};
        tbl[5]  = '{1'b0, 1'b0,  0, 64'h0, 31, 31, 64'h0, 64'h0, 64'h0, 64'h0};
        tbl[6]  = '{1'b0, 1'b1,  3, 64'hA, 3, 3, 64'hA, 64'hA, 64'h0, 64'h0};
        tbl[7]  = '{1'b1, 1'b1,  3, 64'hB, 3, 7, 64'hA, 64'h1234, 64'hA, 64'h1234};
        tbl[8]  = '{1'b0, 1'b0,  0, 64'h0, 3, 7, 64'h0, 64'h0, 64'h0, 64'h0};
        tbl[9]  = '{1'b0, 1'b1,  3, 64'hC, 3, 5, 64'hC, 64'h0, 64'h0, 64'h0};
        tbl[10] = '{1'b0, 1'b0,  0, 64'h0, 3, 3, 64'hC, 64'hC, 64'hC, 64'hC};
        tbl[11] = '{1'b0, 1'b1,  9, 64'h55, 9, 9, 64'h55, 64'h55, 64'h0, 64'h0};

        rst_c = 1'b1; we_c = 1'b0; wa_c = '0; wd_c = '0; ra_c = '0;

        // Reset, then every entry reads 0 on both ports of both copies.
        drive(1, 1, 4, 64'hFFFF, 0, 0);
        tick();
        drive(1, 0, 0, 64'h0, 0, 0);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 64'h0, i, 31 - i);
            check($sformatf("rst_a_p0[%0d]", i), {64'h0, rd_a[63:0]}, 128'h0);
            check($sformatf("rst_a_p1[%0d]", i), {64'h0, rd_a[127:64]}, 128'h0);
            check($sformatf("rst_b_p0[%0d]", i), {64'h0, rd_b[63:0]}, 128'h0);
            check($sformatf("rst_b_p1[%0d]", i), {64'h0, rd_b[127:64]}, 128'h0);
            tick();
        end

        // Directed vector table, compared before each edge.
        for (int v = 0; v < 12; v++) begin
            drive(tbl[v].r, tbl[v].e, tbl[v].a, tbl[v].d, tbl[v].r0, tbl[v].r1);
            check($sformatf("vec%0d_byp_p0", v), {64'h0, rd_a[63:0]},   {64'h0, tbl[v].e0});
            check($sformatf("vec%0d_byp_p1", v), {64'h0, rd_a[127:64]}, {64'h0, tbl[v].e1});
            check($sformatf("vec%0d_nob_p0", v), {64'h0, rd_b[63:0]},   {64'h0, tbl[v].n0});
            check($sformatf("vec%0d_nob_p1", v), {64'h0, rd_b[127:64]}, {64'h0, tbl[v].n1});
            tick();
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit          r;
            bit          e;
            int          a;
            int          r0;
            int          r1;
            logic [63:0] d;
            r  = ($urandom_range(0, 39) == 0);
            e  = $urandom_range(0, 1) == 1;
            a  = $urandom_range(0, 31);
            d  = {$urandom, $urandom};
            r0 = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 31);
            r1 = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 31);
            drive(r, e, a, d, r0, r1);
            check($sformatf("rnd%0d_byp_p0", n), {64'h0, rd_a[63:0]},   {64'h0, model_read(r0, 1)});
            check($sformatf("rnd%0d_byp_p1", n), {64'h0, rd_a[127:64]}, {64'h0, model_read(r1, 1)});
            check($sformatf("rnd%0d_nob_p0", n), {64'h0, rd_b[63:0]},   {64'h0, model_read(r0, 0)});
            check($sformatf("rnd%0d_nob_p1", n), {64'h0, rd_b[127:64]}, {64'h0, model_read(r1, 0)});
            tick();
        end
        drive(0, 0, 0, 64'h0, 0, 0);

        // Small configuration: no zero entry, three ports, index 3 is ordinary.
        rst_c = 1'b1;
        @(posedge clk); #1;
        rst_c = 1'b0;
        ra_c  = {2'd2, 2'd1, 2'd0};
        #1;
        check("small_after_reset", {104'h0, rd_c}, {104'h0, 24'h000000});
        for (int i = 0; i < 4; i++) begin
            we_c = 1'b1;
            wa_c = 2'(i);
            wd_c = 8'(8'h10 + i);
            ra_c = {2'(i), 2'(i), 2'(i)};
            #1;
            check($sformatf("small_bypass_w%0d", i), {104'h0, rd_c},
                  {104'h0, {3{8'(8'h10 + i)}}});
            @(posedge clk); #1;
        end
        we_c = 1'b0;
        ra_c = {2'd3, 2'd0, 2'd3};
        #1;
        check("small_read_303", {104'h0, rd_c}, {104'h0, 24'h131013});
        ra_c = {2'd2, 2'd1, 2'd0};
        #1;
        check("small_read_210", {104'h0, rd_c}, {104'h0, 24'h121110});
        // A dropped write (wr_en=0) leaves the contents untouched.
        wa_c = 2'd3;
        wd_c = 8'hEE;
        @(posedge clk); #1;
        ra_c = {2'd3, 2'd3, 2'd3};
        #1;
        check("small_hold", {104'h0, rd_c}, {104'h0, 24'h131313});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
